// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types for the register file and its bench.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Architectural register names used by software conventions
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  // True for the hardwired-zero register
  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: index -> data with the $0 mask.
// Build option: REGFILE_BYPASS_EN makes the port write-first (forwards the
// in-flight write-back value when the indices match).
module rf_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] rd_data
);

  logic idx_is_zero;

  assign idx_is_zero = (rd_idx == ADDR_W'(REG_ZERO));

`ifndef REGFILE_BYPASS_EN
  // Write-side inputs only matter when forwarding is built in
  logic unused_wr_side;
  assign unused_wr_side = ^{reg_write, write_reg, write_data};
`endif

  // Select stored value, optionally forward the write, then force 0 for $0 and reset
  always_comb begin
    rd_data = regs[rd_idx];
`ifdef REGFILE_BYPASS_EN
    // reg_write is tested first so an X index on an idle write side cannot leak through
    if (reg_write && (rd_idx == write_reg)) begin
      rd_data = write_data;
    end
`endif
    if (rst || idx_is_zero) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit MIPS general-purpose register file: two operand read ports,
// one synchronous write port, one never-bypassed debug read port.
// Build option: REGFILE_BYPASS_EN (write-first operand reads).
module reg_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_reg,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NumEntries = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NumEntries];
  logic              wr_en;

  // $0 is never written, so its storage stays at its reset value of zero
  assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

  // Storage: async clear on reset, single write per rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumEntries; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rd1 (
    .rst       (rst),
    .rd_idx    (read_reg1),
    .regs      (regs_q),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .rd_data   (read_data1)
  );

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rd2 (
    .rst       (rst),
    .rd_idx    (read_reg2),
    .regs      (regs_q),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .rd_data   (read_data2)
  );

  // Debug view always shows committed state, so its forwarding path is tied off
  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dbg (
    .rst       (rst),
    .rd_idx    (dbg_reg),
    .regs      (regs_q),
    .reg_write (1'b0),
    .write_reg ({ADDR_W{1'b0}}),
    .write_data({DATA_W{1'b0}}),
    .rd_data   (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic
// compared against an array model of the architectural register state.
module tb_reg_file;
  import mips_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  dbg_reg;
  logic [31:0] dbg_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] model [32];

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .dbg_reg   (dbg_reg),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Architectural view of a read given the current inputs
  function automatic logic [31:0] ref_read(input logic [4:0] idx, input bit fwd_ok);
    if (rst || idx == 5'd0) return 32'h0;
    if (Bypass && fwd_ok && reg_write === 1'b1 && idx == write_reg) return write_data;
    return model[idx];
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_rd1"}, read_data1, ref_read(read_reg1, 1'b1));
    check({tag, "_rd2"}, read_data2, ref_read(read_reg2, 1'b1));
    check({tag, "_dbg"}, dbg_data, ref_read(dbg_reg, 1'b0));
  endtask

  // Advance one rising edge, commit to the model, settle 1ns past the edge
  task automatic step();
    @(posedge clk);
    if (!rst && reg_write === 1'b1 && write_reg != 5'd0) model[write_reg] = write_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic write(input logic [4:0] idx, input logic [31:0] data);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = data;
    step();
    reg_write  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      dbg_reg   = 5'(i);
      #1;
      check_ports(tag);
    end
  endtask

  initial begin
    rst        = 1'b1;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    dbg_reg    = '0;
    clear_model();
    repeat (2) step();
    rst = 1'b0;
    check_all("reset_init");

    // Basic write then read
    read_reg1 = 5'd8;
    read_reg2 = 5'd9;
    write(5'd8, 32'hDEADBEEF);
    check("basic_rd1", read_data1, 32'hDEADBEEF);
    check("basic_rd2", read_data2, 32'h0);

    // Fill every writable register with index * 0x01010101
    for (int i = 1; i < 32; i++) write(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(i);
      dbg_reg   = 5'(i);
      #1;
      check("fill_rd1", read_data1, 32'(i) * 32'h01010101);
      check("fill_rd2", read_data2, 32'(i) * 32'h01010101);
    end

    // $0 stays zero
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    dbg_reg   = 5'd0;
    write(5'd0, 32'hFFFFFFFF);
    check("zero_rd1", read_data1, 32'h0);
    check("zero_rd2", read_data2, 32'h0);
    check("zero_dbg", dbg_data, 32'h0);
    check_all("zero_others");

    // Write enable low holds state, including with unknown write-side inputs
    write(5'd5, 32'hA5A5A5A5);
    write_reg  = 5'd5;
    write_data = 32'h12345678;
    read_reg1  = 5'd5;
    repeat (3) step();
    check("we_low_hold", read_data1, 32'hA5A5A5A5);
    write_reg  = 'x;
    write_data = 'x;
    repeat (2) step();
    check("we_low_x_hold", read_data1, 32'hA5A5A5A5);
    write_reg  = '0;
    write_data = '0;
    check_all("we_low_all");

    // Read during write, same index
    write(5'd3, 32'h11111111);
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'h22222222;
    read_reg1  = 5'd3;
    read_reg2  = 5'd3;
    dbg_reg    = 5'd3;
    #1;
    check("rdw_pre_rd1", read_data1, Bypass ? 32'h22222222 : 32'h11111111);
    check("rdw_pre_rd2", read_data2, Bypass ? 32'h22222222 : 32'h11111111);
    check("rdw_pre_dbg", dbg_data, 32'h11111111);
    step();
    reg_write = 1'b0;
    #1;
    check("rdw_post_rd1", read_data1, 32'h22222222);
    check("rdw_post_rd2", read_data2, 32'h22222222);

    // Back-to-back writes to $31
    read_reg1  = REG_RA;
    read_reg2  = 5'd30;
    reg_write  = 1'b1;
    write_reg  = REG_RA;
    write_data = 32'h1;
    step();
    check("b2b_first", read_data1, 32'h1);
    write_data = 32'h2;
    step();
    reg_write = 1'b0;
    #1;
    check("b2b_second", read_data1, 32'h2);
    check("b2b_neighbour", read_data2, 32'd30 * 32'h01010101);

    // Async reset mid-cycle: outputs drop before the next edge, writes ignored
    read_reg1 = 5'd8;
    read_reg2 = REG_SP;
    dbg_reg   = 5'd5;
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd1", read_data1, 32'h0);
    check("arst_rd2", read_data2, 32'h0);
    check("arst_dbg", dbg_data, 32'h0);
    clear_model();
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 32'hCAFEF00D;
    step();
    // Release mid-cycle: the write presented in this cycle is taken
    rst        = 1'b0;
    write_data = 32'h0BADF00D;
    step();
    reg_write = 1'b0;
    dbg_reg   = 5'd7;
    #1;
    check("rst_release_write", dbg_data, 32'h0BADF00D);
    check_all("post_reset");

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      if (rst) clear_model();
      reg_write  = $urandom_range(0, 1);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      dbg_reg    = 5'($urandom_range(0, 31));
      #1;
      check_ports("rand_pre");
      step();
      rst = 1'b0;
    end
    reg_write = 1'b0;
    #1;
    check_all("rand_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly downstream of the write-back 2:1 select: it consumes the selected result (ALU result vs. memory load data) as write_data.
- Supplies the two source operands to the ALU input selects.
- Two combinational read ports, one synchronous write port, plus one debug read port for bench inspection.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable from control.
- write_reg  input  ADDR_W  destination register index (rd/rt, already selected upstream).
- write_data  input  DATA_W  write-back value from the result select.
- read_reg1  input  ADDR_W  rs index.
- read_reg2  input  ADDR_W  rt index.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.
- dbg_reg  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  contents of dbg_reg (never bypassed).

Behaviour:
- Storage: 32 entries of DATA_W bits.
- Reset:
  - rst high clears every entry to 0 immediately, independent of clk.
  - While rst is high, all read outputs read 0 and writes are ignored.
  - Deassertion is taken at the next rising edge; a write presented in that cycle is accepted.
- Write:
  - On a rising clk edge with rst=0 and reg_write=1, entry[write_reg] <= write_data.
  - Latency is 1 cycle: the value is visible on read ports after the edge.
- Register $0:
  - Hardwired zero. Writes to index 0 are discarded; entry 0 is never modified.
  - Reads of index 0 always return 0, including through the bypass path.
- Read:
  - Purely combinational from index to data, zero latency; no read enable.
  - Both ports may address the same register; both return the same value.
- Read-during-write, same index, same cycle (no bypass): the read returns the old value until the edge, then the new value.
- reg_write=0: no state change, whatever write_reg/write_data carry. X on write_reg or write_data with reg_write=0 must not corrupt state.
- Index width is exactly ADDR_W, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - read_dataN = write_data combinationally when reg_write=1 and read_regN == write_reg != 0 and rst=0.
  - This is write-first behaviour, so the pipeline needs no separate WB->ID forwarding.
  - dbg_data is not bypassed.
- Undefined: read-first behaviour exactly as in Behaviour; the hazard is resolved by the hazard unit (stall, or write on the negative edge elsewhere).

Decomposition:
- Shared package mips_pkg:
  - DATA_W=32, ADDR_W=5, NUM_REGS=32.
  - REG_ZERO=5'd0.
  - Optional named indices REG_SP=29, REG_RA=31 for bench use.
  - Typedef word_t [31:0] and reg_idx_t [4:0].
- Sub-module: one natural sub-module, rf_read_port (index + storage view + write-side signals -> data, with the $0 mask and optional bypass), instantiated three times.
  - For the debug instance, the bypass is tied off: reg_write input forced to 0.

Test Plan:
- Reset: load several registers, then assert rst asynchronously mid-cycle -> all read_data1/2 and dbg_data = 0 before the next edge; after release, every index reads 0.
- Basic write/read:
  - write 0xDEADBEEF to $8 with reg_write=1 -> read_reg1=8 gives 0xDEADBEEF after the edge.
  - read_reg2=9 gives 0.
  - Repeat for all 31 writable indices with data = index*0x01010101; read all back on both ports.
- $0 protection: write 0xFFFFFFFF to $0 -> read_data1/read_data2/dbg_data at index 0 = 0; all other registers unchanged.
- Write enable: reg_write=0 with write_reg=5, write_data=0x12345678 over several edges -> $5 keeps its prior value 0xA5A5A5A5.
- Read-during-write: $3=0x11111111; same cycle write $3=0x22222222 with read_reg1=read_reg2=3 ->
  - without REGFILE_BYPASS_EN: 0x11111111 before the edge, 0x22222222 after;
  - with it: 0x22222222 immediately;
  - dbg_data=0x11111111 before the edge in both builds.
- Back-to-back writes: write $31=1 then $31=2 on consecutive edges while read_reg1=31 -> 1 then 2, one cycle apart; $30 unaffected.
